// File: rtl/sram_cache_controller_if.sv
// Bus bundle between the MEM stage, the cache controller and the SRAM controller.
// slave is the cache controller's view; master is the view of whatever drives the
// MEM-stage requests and answers the SRAM transactions.
interface sram_cache_controller_if;
  // MEM-stage side
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  // SRAM-controller side
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );

  modport master (
    output mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );
endinterface

// File: rtl/sram_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache in front of the
// SRAM controller. Read hits answer combinationally; a read miss fetches the
// 2-word block with two SRAM reads; every store goes straight to SRAM and only
// updates the cache if the line is already present.
module sram_cache_controller #(
  parameter int SETS      = 64,
  parameter int TAG_W     = 10,
  parameter int BASE_ADDR = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_cache_controller_if.slave bus
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int HI      = INDEX_W + TAG_W + 2;
  localparam logic [31:0] BASE32 = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, WRITE} state_t;

  state_t            state_q;
  logic [1:0]        valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [63:0]       data_q  [2][SETS];
  logic [SETS-1:0]   lru_q;
  logic              sram_r_en_q;
  logic              sram_w_en_q;
  logic [31:0]       sram_address_q;
  logic [31:0]       sram_wdata_q;
  logic [31:0]       word0_q;

  // Lookup address: the live request while idle, otherwise the latched
  // transaction address, so a request dropped mid-transaction still completes.
  logic [HI:2]        lk_word;
  logic [HI:2]        a_w;
  logic               lk_off;
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               hit0, hit1, hit;
  logic [63:0]        hit_line;
  logic [31:0]        hit_word;
  logic               victim;
  logic               rd_req;

  assign lk_word  = (state_q == IDLE) ? bus.address[HI:2] : sram_address_q[HI:2];
  assign a_w      = lk_word - BASE32[HI:2];
  assign lk_off   = a_w[2];
  assign lk_idx   = a_w[INDEX_W+2:3];
  assign lk_tag   = a_w[HI:INDEX_W+3];
  assign hit0     = valid_q[lk_idx][0] && (tag_q[0][lk_idx] == lk_tag);
  assign hit1     = valid_q[lk_idx][1] && (tag_q[1][lk_idx] == lk_tag);
  assign hit      = hit0 | hit1;
  assign hit_line = hit1 ? data_q[1][lk_idx] : data_q[0][lk_idx];
  assign hit_word = lk_off ? hit_line[63:32] : hit_line[31:0];
  // Fill victim: first invalid way (way0 preferred), else the LRU way.
  assign victim   = !valid_q[lk_idx][0] ? 1'b0 :
                    (!valid_q[lk_idx][1] ? 1'b1 : lru_q[lk_idx]);
  // A simultaneous load and store is treated as a load.
  assign rd_req   = bus.mem_r_en;

  assign bus.sram_r_en    = sram_r_en_q;
  assign bus.sram_w_en    = sram_w_en_q;
  assign bus.sram_address = sram_address_q;
  assign bus.sram_wdata   = sram_wdata_q;

  // Pipeline handshake: hits complete in the request cycle, stores on sram_ready.
  always_comb begin
    bus.ready = 1'b1;
    bus.rdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          bus.ready = hit;
          if (hit) bus.rdata = hit_word;
        end else if (bus.mem_w_en) begin
          bus.ready = 1'b0;
        end
      end
      FILL0, FILL1: bus.ready = 1'b0;
      WRITE:        bus.ready = bus.sram_ready;
      default:      bus.ready = 1'b1;
    endcase
  end

  // Controller FSM with registered SRAM requests and cache array updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sram_r_en_q    <= 1'b0;
      sram_w_en_q    <= 1'b0;
      sram_address_q <= 32'h0;
      sram_wdata_q   <= 32'h0;
      word0_q        <= 32'h0;
      lru_q          <= '0;
      for (int i = 0; i < SETS; i++) valid_q[i] <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            if (hit) begin
              lru_q[lk_idx] <= ~hit1;
            end else begin
              state_q        <= FILL0;
              sram_r_en_q    <= 1'b1;
              sram_address_q <= {bus.address[31:3], 3'b000};
            end
          end else if (bus.mem_w_en) begin
            state_q        <= WRITE;
            sram_w_en_q    <= 1'b1;
            sram_address_q <= bus.address;
            sram_wdata_q   <= bus.wdata;
          end
        end
        FILL0: begin
          if (bus.sram_ready) begin
            word0_q        <= bus.sram_rdata;
            sram_address_q <= sram_address_q + 32'd4;
            state_q        <= FILL1;
          end
        end
        FILL1: begin
          if (bus.sram_ready) begin
            sram_r_en_q                <= 1'b0;
            state_q                    <= IDLE;
            data_q[victim][lk_idx]     <= {bus.sram_rdata, word0_q};
            tag_q[victim][lk_idx]      <= lk_tag;
            valid_q[lk_idx][victim]    <= 1'b1;
            lru_q[lk_idx]              <= ~victim;
          end
        end
        WRITE: begin
          if (bus.sram_ready) begin
            sram_w_en_q <= 1'b0;
            state_q     <= IDLE;
            if (hit) begin
              data_q[hit1][lk_idx][{lk_off, 5'd0} +: 32] <= sram_wdata_q;
              lru_q[lk_idx]                              <= ~hit1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_cache_controller.sv
// Bench for sram_cache_controller: an SRAM-controller model with random
// latency answers the cache, and a recency-list cache model plus a flat
// memory image predict data, hit/miss and SRAM traffic per transaction.
module tb_sram_cache_controller;
  logic clk;
  logic rst;

  sram_cache_controller_if bus();

  sram_cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Initial memory contents, shared definition for SRAM model and reference image.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // ---------------- SRAM controller model ----------------
  logic [31:0] sram_mem [logic [31:0]];
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] rd_log [$];
  bit          busy = 0;
  int          lat = 0;

  function automatic logic [31:0] sram_get(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bus.sram_ready = 1'b0;
      bus.sram_rdata = 32'h0;
      busy = 0;
    end else if (bus.sram_ready) begin
      bus.sram_ready = 1'b0;
      busy = 0;
    end else if (bus.sram_r_en || bus.sram_w_en) begin
      if (!busy) begin
        busy = 1;
        lat  = $urandom_range(0, 3);
      end
      if (lat == 0) begin
        bus.sram_ready = 1'b1;
        if (bus.sram_r_en) begin
          bus.sram_rdata = sram_get(bus.sram_address);
          n_rd++;
          rd_log.push_back(bus.sram_address);
        end else begin
          sram_mem[bus.sram_address] = bus.sram_wdata;
          n_wr++;
        end
      end else begin
        lat--;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mru_blk [64];
  logic [31:0] lru_blk [64];
  int          n_in    [64];

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic int set_of(input logic [31:0] blk);
    return int'(((blk - 32'd1024) / 32'd8) % 32'd64);
  endfunction

  function automatic bit ref_hit(input logic [31:0] blk);
    int s = set_of(blk);
    return (n_in[s] >= 1 && mru_blk[s] == blk) || (n_in[s] == 2 && lru_blk[s] == blk);
  endfunction

  task automatic ref_touch(input logic [31:0] blk);
    int s = set_of(blk);
    if (n_in[s] == 2 && lru_blk[s] == blk) begin
      lru_blk[s] = mru_blk[s];
      mru_blk[s] = blk;
    end
  endtask

  task automatic ref_insert(input logic [31:0] blk);
    int s = set_of(blk);
    if (n_in[s] >= 1) lru_blk[s] = mru_blk[s];
    mru_blk[s] = blk;
    if (n_in[s] < 2) n_in[s]++;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 64; i++) n_in[i] = 0;
  endtask

  // ---------------- transaction driver ----------------
  logic        t_first_ready;
  logic [31:0] t_data;
  int          t_nrd;
  int          t_nwr;

  task automatic run_txn(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] wd);
    int  rd0 = n_rd;
    int  wr0 = n_wr;
    bit  first = 1;
    bit  done = 0;
    rd_log.delete();
    @(posedge clk); #1;
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = addr;
    bus.wdata    = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk); #1;
      if (first) begin
        t_first_ready = bus.ready;
        first = 0;
      end
      if (bus.ready) begin
        t_data = bus.rdata;
        done = 1;
      end
    end
    if (!done) check_value("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    t_nrd = n_rd - rd0;
    t_nwr = n_wr - wr0;
  endtask

  task automatic read_check(input logic [31:0] addr, input logic both);
    logic [31:0] blk = {addr[31:3], 3'b000};
    bit          hit = ref_hit(blk);
    logic [31:0] exp = ref_get(addr);
    run_txn(1'b1, both, addr, $urandom);
    check_value("rd_data", t_data, exp);
    check_value("rd_hit", {31'b0, t_first_ready}, {31'b0, hit});
    check_value("rd_sram_reads", t_nrd, hit ? 0 : 2);
    check_value("rd_sram_writes", t_nwr, 0);
    if (!hit && rd_log.size() == 2) begin
      check_value("fill_addr0", rd_log[0], blk);
      check_value("fill_addr1", rd_log[1], blk + 32'd4);
    end
    if (hit) ref_touch(blk);
    else     ref_insert(blk);
    $display("read  %08h hit=%0d data=%08h", addr, t_first_ready, t_data);
  endtask

  task automatic write_check(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] blk = {addr[31:3], 3'b000};
    run_txn(1'b0, 1'b1, addr, wd);
    check_value("wr_ready_first", {31'b0, t_first_ready}, 32'd0);
    check_value("wr_sram_writes", t_nwr, 1);
    check_value("wr_sram_reads", t_nrd, 0);
    check_value("wr_sram_data", sram_get(addr), wd);
    ref_mem[addr] = wd;
    if (ref_hit(blk)) ref_touch(blk);
    $display("write %08h data=%08h", addr, wd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = 32'h0;
    bus.wdata    = 32'h0;
    ref_clear();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_value("rst_ready", {31'b0, bus.ready}, 32'd1);
    check_value("rst_sram_r_en", {31'b0, bus.sram_r_en}, 32'd0);
    check_value("rst_sram_w_en", {31'b0, bus.sram_w_en}, 32'd0);
    check_value("rst_rdata", bus.rdata, 32'h0);
    check_value("rst_sram_address", bus.sram_address, 32'h0);
    check_value("rst_sram_wdata", bus.sram_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss fills the block, held request then hits
    sram_mem[32'h400] = 32'h11111111; ref_mem[32'h400] = 32'h11111111;
    sram_mem[32'h404] = 32'h22222222; ref_mem[32'h404] = 32'h22222222;
    read_check(32'h400, 1'b0);
    check_value("t1_data", t_data, 32'h11111111);
    check_value("t1_miss", {31'b0, t_first_ready}, 32'd0);
    // Other word of the block hits without SRAM traffic
    read_check(32'h404, 1'b0);
    check_value("t2_data", t_data, 32'h22222222);
    check_value("t2_no_sram", t_nrd, 0);
    // Store to a cached word, then load it back
    write_check(32'h400, 32'hDEADBEEF);
    read_check(32'h400, 1'b0);
    check_value("t3_data", t_data, 32'hDEADBEEF);
    check_value("t3_hit", {31'b0, t_first_ready}, 32'd1);
    // LRU eviction in set 0
    read_check(32'h400, 1'b0);
    read_check(32'h600, 1'b0);
    read_check(32'h400, 1'b0);
    read_check(32'h800, 1'b0);
    read_check(32'h400, 1'b0);
    check_value("t4_a_hit", {31'b0, t_first_ready}, 32'd1);
    read_check(32'h600, 1'b0);
    check_value("t4_b_miss", {31'b0, t_first_ready}, 32'd0);
    // Uncached store: no allocation
    write_check(32'h1000, 32'h5);
    read_check(32'h1000, 1'b0);
    check_value("t5_miss", {31'b0, t_first_ready}, 32'd0);
    check_value("t5_data", t_data, 32'h5);

    // Reset during the second fill read
    @(posedge clk); #1;
    bus.mem_r_en = 1'b1;
    bus.address  = 32'h1228;
    found = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk); #1;
      if (bus.sram_r_en && bus.sram_address == 32'h122C) found = 1;
    end
    check_value("t6_reach_fill1", {31'b0, found}, 32'd1);
    rst = 1'b1;
    bus.mem_r_en = 1'b0;
    @(posedge clk); #1;
    check_value("t6_sram_r_en", {31'b0, bus.sram_r_en}, 32'd0);
    check_value("t6_ready", {31'b0, bus.ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_clear();
    $display("reset during fill");
    read_check(32'h400, 1'b0);
    check_value("t6_miss_again", {31'b0, t_first_ready}, 32'd0);

    // Random mix over 4 sets x 4 tags so hits, misses and evictions all occur
    for (int n = 0; n < 250; n++) begin
      int unsigned op  = $urandom_range(0, 9);
      logic [31:0] a   = 32'h400 + 32'($urandom_range(0, 3)) * 32'd8
                       + 32'($urandom_range(0, 3)) * 32'h200
                       + 32'($urandom_range(0, 1)) * 32'd4;
      if (op < 6) read_check(a, op == 0);
      else        write_check(a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
